aes_out_serializer: RTL and testbench

Downstream consumer of the last AES round stage. Captures every registered out_packet_t the round emits into a small FIFO, because the round pipeline has no backpressure. Drains each 128-bit result to the host/bus side as WORD_W-bit words over a valid/ready handshake. Flags packets lost to overflow.

---
 rtl/aes_out_serializer_pkg.sv | 31 +++
 rtl/aes_pkt_fifo.sv | 71 +++++++
 rtl/aes_out_serializer.sv | 178 +++++++++++++++++
 tb/tb_aes_out_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_out_serializer_pkg.sv
// -----------------------------------------------------------------------------
// aes_out_serializer_pkg
// Shared types for the AES output serializer slice.
//   out_packet_t : registered packet emitted by the last AES round
//                  {valid, data[127:0], en_de}; en_de=1 marks a decrypt result
//   fifo_entry_t : what the serializer FIFO stores per block {data, en_de}
//   ser_state_t  : serializer FSM states
// -----------------------------------------------------------------------------
package aes_out_serializer_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef struct packed {
    logic                   valid;
    logic [AES_BLOCK_W-1:0] data;
    logic                   en_de;
  } out_packet_t;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] data;
    logic                   en_de;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_W = AES_BLOCK_W + 1;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

endpackage

// File: rtl/aes_pkt_fifo.sv
// -----------------------------------------------------------------------------
// aes_pkt_fifo
// Synchronous FIFO holding whole AES result blocks for the serializer.
// Pointers carry one extra MSB so full and empty are told apart without
// sacrificing a slot. The head and the entry behind it are both exposed so the
// consumer can start the next block on the same edge the head is popped.
//
// Parameters: DEPTH (power of 2, >= 2), ENTRY_W (entry width in bits)
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers only)
//   push      : write wr_data (accepted when not full, or when popping)
//   wr_data   : entry to write
//   pop       : remove the head entry (ignored when empty)
//   rd_data   : head entry
//   rd_next   : entry behind the head (valid when count >= 2)
//   full      : DEPTH entries held
//   empty     : no entries held
//   count     : entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module aes_pkt_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 129
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [ENTRY_W-1:0]       rd_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // A push into a full FIFO is only legal when the head leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign rd_next = mem[rd_ptr[AW-1:0] + AW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries data only; stale contents are never visible because the
  // pointers gate every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
// Captures every valid packet from the last AES round into a FIFO (the round
// has no backpressure) and drains each 128-bit block as WORD_W-bit words,
// MSB word first, over a valid/ready handshake. Packets arriving while the
// FIFO is full and no block is completing are dropped and flagged.
//
// Parameters: DEPTH  (FIFO entries, power of 2, >= 2)
//             WORD_W (output word width, must divide 128)
// Optional build macro: AES_OUT_PARITY_EN adds out_parity, the XOR of out_word.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_pkt        : out_packet_t from the last round
//   out_word      : current output word
//   out_valid     : out_word/out_last/out_en_de valid
//   out_ready     : consumer accepts the word this cycle
//   out_last      : final word of a block
//   out_en_de     : en_de of the block being sent
//   occupancy     : FIFO entries held, including the block being sent
//   overflow      : sticky drop flag
//   clr_overflow  : clears overflow (a same-cycle drop wins)
//   out_parity    : (AES_OUT_PARITY_EN only) even parity of out_word
// -----------------------------------------------------------------------------
module aes_out_serializer
  import aes_out_serializer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  out_packet_t              in_pkt,
  output logic [WORD_W-1:0]        out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_en_de,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef AES_OUT_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int WPB   = AES_BLOCK_W / WORD_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  // Word k of a block, counting from the most significant end
  function automatic logic [WORD_W-1:0] word_sel(input logic [AES_BLOCK_W-1:0] data,
                                                 input logic [IDX_W-1:0]       k);
    logic [AES_BLOCK_W-1:0] sh;
    sh = data << (int'(k) * WORD_W);
    return sh[AES_BLOCK_W-1 -: WORD_W];
  endfunction

  ser_state_t         state;
  logic [IDX_W-1:0]   idx;

  fifo_entry_t        in_ent;
  fifo_entry_t        head;
  fifo_entry_t        head_next;
  fifo_entry_t        load_ent;
  logic [IDX_W-1:0]   load_idx;
  logic               load;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;

  assign in_ent    = {in_pkt.data, in_pkt.en_de};
  assign occupancy = count;

  aes_pkt_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (FIFO_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_ent),
    .pop     (pop),
    .rd_data (head),
    .rd_next (head_next),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Decide what the output register loads next. When the final word of the
  // head is accepted, the following block comes from the FIFO slot behind the
  // head, or straight from in_pkt if it is being written into an otherwise
  // empty FIFO on this very edge, so consecutive blocks leave without a bubble.
  always_comb begin
    load     = 1'b0;
    load_ent = head;
    load_idx = '0;
    pop      = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!empty) load = 1'b1;
      end
      SER_SEND: begin
        if (out_ready) begin
          if (out_last) begin
            pop = 1'b1;
            if (count >= CNT_W'(2)) begin
              load     = 1'b1;
              load_ent = head_next;
            end else if (in_pkt.valid) begin
              load     = 1'b1;
              load_ent = in_ent;
            end
          end else begin
            load     = 1'b1;
            load_idx = idx + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // The head pop frees a slot on the same edge, so a full FIFO can still
  // accept a packet that coincides with a final-word handshake
  assign push = in_pkt.valid && (!full || pop);
  assign drop = in_pkt.valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      idx       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_en_de <= 1'b0;
      overflow  <= 1'b0;
`ifdef AES_OUT_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      case (state)
        SER_IDLE, SER_SEND: begin
          if (load) begin
            state     <= SER_SEND;
            idx       <= load_idx;
            out_word  <= word_sel(load_ent.data, load_idx);
            out_valid <= 1'b1;
            out_last  <= (load_idx == LAST_IDX);
            out_en_de <= load_ent.en_de;
`ifdef AES_OUT_PARITY_EN
            out_parity <= ^word_sel(load_ent.data, load_idx);
`endif
          end else if (state == SER_SEND && out_ready) begin
            // Final word accepted and nothing queued behind it
            state     <= SER_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_out_serializer
// Self-checking bench for aes_out_serializer (DEPTH=4, WORD_W=32): a per-cycle
// vector table for the basic, filler and decrypt transfers, then hand-written
// sequences for backpressure, overflow, full-with-pop and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;
  import aes_out_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  out_packet_t in_pkt;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_en_de;
  logic [2:0]  occupancy;
  logic        overflow;
  logic        clr_overflow;

  always #5 clk = ~clk;

  aes_out_serializer #(
    .DEPTH  (4),
    .WORD_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_pkt       (in_pkt),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_en_de    (out_en_de),
    .occupancy    (occupancy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK_P = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_D = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic         iv;
    logic [127:0] id;
    logic         ie;
    logic         rdy;
    logic         ev;
    logic [31:0]  ew;
    logic         el;
    logic         ee;
    logic [2:0]   eo;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];
  logic        exp_l[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_pkt = '{valid: 1'b0, data: 128'hdeadbeef, en_de: 1'b0};
  endtask

  task automatic send(input logic [127:0] d, input logic e);
    in_pkt = '{valid: 1'b1, data: d, en_de: e};
    tick();
    idle_in();
  endtask

  task automatic addv(input logic iv, input logic [127:0] id, input logic ie, input logic rdy,
                      input logic ev, input logic [31:0] ew, input logic el, input logic ee,
                      input logic [2:0] eo);
    vec_t v;
    v.iv = iv; v.id = id; v.ie = ie; v.rdy = rdy;
    v.ev = ev; v.ew = ew; v.el = el; v.ee = ee; v.eo = eo;
    vq.push_back(v);
  endtask

  // Synthetic block p: word w is B000_0pww
  function automatic logic [31:0] pw(input int p, input int w);
    return 32'hB000_0000 | (32'(p) << 8) | 32'(w);
  endfunction

  function automatic logic [127:0] mkblk(input int p);
    return {pw(p, 0), pw(p, 1), pw(p, 2), pw(p, 3)};
  endfunction

  task automatic expect_blk(input int p);
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back(pw(p, w));
      exp_l.push_back(w == 3);
    end
  endtask

  // Drive out_ready (always 1, or the 1,0,0 pattern), compare each accepted
  // word against the expectation queue and check stability while stalled
  task automatic drain(input bit toggle, input int maxc);
    logic        pv;
    logic        pr;
    logic [31:0] prev_w;
    logic        r;
    logic [31:0] ew;
    logic        el;
    pv = 1'b0; pr = 1'b1; prev_w = '0;
    for (int c = 0; c < maxc && exp_q.size() > 0; c++) begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_word", out_word, prev_w);
      end
      r = toggle ? (c % 3 == 0) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        ew = exp_q.pop_front();
        el = exp_l.pop_front();
        chk("drain_word", out_word, ew);
        chk("drain_last", out_last, el);
      end
      pv = out_valid; pr = r; prev_w = out_word;
      tick();
    end
    chk("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    exp_l.delete();
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0; clr_overflow = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_word", out_word, 32'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_en_de", out_en_de, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;

    // Basic transfer, filler packet, decrypt packet
    addv(1'b1, BLK_P,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h69c4e0d8, 1'b0, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h6a7b0430, 1'b0, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'hd8cdb780, 1'b0, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h70b4c55a, 1'b1, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    addv(1'b0, 128'hdeadbeef,1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    addv(1'b1, BLK_D,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h00112233, 1'b0, 1'b1, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h44556677, 1'b0, 1'b1, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'h8899aabb, 1'b0, 1'b1, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b1, 32'hccddeeff, 1'b1, 1'b1, 3'd1);
    addv(1'b0, 128'h0,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);

    for (int i = 0; i < vq.size(); i++) begin
      in_pkt    = '{valid: vq[i].iv, data: vq[i].id, en_de: vq[i].ie};
      out_ready = vq[i].rdy;
      tick();
      chk("tbl_valid", out_valid, vq[i].ev);
      if (vq[i].ev) begin
        chk("tbl_word", out_word, vq[i].ew);
        chk("tbl_en_de", out_en_de, vq[i].ee);
      end
      chk("tbl_last", out_last, vq[i].el);
      chk("tbl_occ", occupancy, vq[i].eo);
      chk("tbl_ovf", overflow, 1'b0);
    end
    idle_in();

    // Backpressure with out_ready 1,0,0,1,...
    send(BLK_P, 1'b0);
    exp_q.push_back(32'h69c4e0d8); exp_l.push_back(1'b0);
    exp_q.push_back(32'h6a7b0430); exp_l.push_back(1'b0);
    exp_q.push_back(32'hd8cdb780); exp_l.push_back(1'b0);
    exp_q.push_back(32'h70b4c55a); exp_l.push_back(1'b1);
    drain(1'b1, 60);
    chk("bp_valid_after", out_valid, 1'b0);
    chk("bp_occ_after", occupancy, 3'd0);

    // Overflow: five packets into a stalled 4-entry FIFO
    out_ready = 1'b0;
    for (int p = 1; p <= 5; p++) send(mkblk(p), 1'b0);
    chk("ovf_occ", occupancy, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", out_word, pw(1, 0));
    for (int p = 1; p <= 4; p++) expect_blk(p);
    drain(1'b0, 100);
    chk("ovf_occ_drained", occupancy, 3'd0);
    chk("ovf_sticky", overflow, 1'b1);

    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_ovf", overflow, 1'b0);

    // Full FIFO, new packet coincides with the final-word handshake
    out_ready = 1'b0;
    for (int p = 11; p <= 14; p++) send(mkblk(p), 1'b0);
    chk("fp_occ_full", occupancy, 3'd4);
    chk("fp_word0", out_word, pw(11, 0));
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("fp_word3", out_word, pw(11, 3));
    chk("fp_last3", out_last, 1'b1);
    in_pkt = '{valid: 1'b1, data: mkblk(15), en_de: 1'b0};
    tick();
    idle_in();
    chk("fp_occ_stays", occupancy, 3'd4);
    chk("fp_no_ovf", overflow, 1'b0);
    chk("fp_next_valid", out_valid, 1'b1);
    chk("fp_next_word", out_word, pw(12, 0));
    for (int p = 12; p <= 15; p++) expect_blk(p);
    drain(1'b0, 100);
    chk("fp_occ_drained", occupancy, 3'd0);
    chk("fp_no_ovf_end", overflow, 1'b0);

    // Clear/drop collision, then reset mid-transfer
    out_ready = 1'b0;
    for (int p = 21; p <= 24; p++) send(mkblk(p), 1'b0);
    in_pkt = '{valid: 1'b1, data: mkblk(25), en_de: 1'b1};
    clr_overflow = 1'b1;
    tick();
    idle_in();
    clr_overflow = 1'b0;
    chk("coll_ovf_set", overflow, 1'b1);
    chk("coll_occ", occupancy, 3'd4);
    out_ready = 1'b1;
    tick(); tick();
    chk("mid_word2", out_word, pw(21, 2));
    rst = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_occ", occupancy, 3'd0);
    chk("mrst_ovf", overflow, 1'b0);
    chk("mrst_word", out_word, 32'h0);
    chk("mrst_last", out_last, 1'b0);
    chk("mrst_en_de", out_en_de, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_occ", occupancy, 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
